// File: rtl/br_pkg.sv
// Shared constants and encodings for the register-bank write arbiter.
package br_pkg;

  localparam int BR_DATA_W = 32;
  localparam int BR_ADDR_W = 5;
  localparam int BR_NREG   = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic {
    GNT_0 = 1'b0,
    GNT_1 = 1'b1
  } gnt_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; purely combinational, the caller owns last_grant.
module rr_arb2
  import br_pkg::*;
(
  input  logic [1:0] eligible_i,
  input  gnt_e       last_grant_i,
  output logic       gnt_valid_o,
  output gnt_e       gnt_idx_o
);

  always_comb begin
    gnt_valid_o = |eligible_i;
    if (&eligible_i) begin
      gnt_idx_o = (last_grant_i == GNT_1) ? GNT_0 : GNT_1;
    end else if (eligible_i[1]) begin
      gnt_idx_o = GNT_1;
    end else begin
      gnt_idx_o = GNT_0;
    end
  end

endmodule

// File: rtl/br_write_arbiter.sv
// Owns the register bank write port: zero-fill sweep after reset, then
// round-robin sharing between two req/ack requesters with registered outputs.
module br_write_arbiter
  import br_pkg::*;
#(
  parameter int DATA_W       = BR_DATA_W,
  parameter int ADDR_W       = BR_ADDR_W,
  parameter int NREG         = BR_NREG,
  parameter bit ZERO_PROTECT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic              WE,
  output logic [ADDR_W-1:0] AW,
  output logic [DATA_W-1:0] DataIn,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
  gnt_e              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] aw_q, aw_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              busy_q, busy_d;

  logic [1:0]        eligible;
  logic              gnt_valid;
  gnt_e              gnt_idx;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  // A requester whose ack is showing this cycle is still holding the old
  // request, so it must sit out one arbitration round.
  assign eligible = {req1 & ~ack1_q, req0 & ~ack0_q};

  rr_arb2 u_arb (
    .eligible_i   (eligible),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_idx_o    (gnt_idx)
  );

  assign gnt_addr = (gnt_idx == GNT_1) ? addr1 : addr0;
  assign gnt_data = (gnt_idx == GNT_1) ? data1 : data0;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    state_d      = state_q;
    init_ptr_d   = init_ptr_q;
    last_grant_d = last_grant_q;
    we_d         = 1'b0;
    aw_d         = aw_q;
    data_d       = data_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    busy_d       = busy_q;

    case (state_q)
      ST_INIT: begin
        we_d       = 1'b1;
        aw_d       = init_ptr_q;
        data_d     = '0;
        init_ptr_d = init_ptr_q + ADDR_W'(1);
        if (init_ptr_q == ADDR_W'(NREG - 1)) begin
          state_d    = ST_RUN;
          busy_d     = 1'b0;
          init_ptr_d = '0;
        end
      end
      ST_RUN: begin
        if (gnt_valid) begin
          last_grant_d = gnt_idx;
          ack0_d       = (gnt_idx == GNT_0);
          ack1_d       = (gnt_idx == GNT_1);
          // Protected address 0: the requester is released but the bank port
          // keeps its previous address/data with WE low.
          if (!(ZERO_PROTECT && (gnt_addr == '0))) begin
            we_d   = 1'b1;
            aw_d   = gnt_addr;
            data_d = gnt_data;
          end
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      init_ptr_q   <= '0;
      last_grant_q <= GNT_1;
      we_q         <= 1'b0;
      aw_q         <= '0;
      data_q       <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      aw_q         <= aw_d;
      data_q       <= data_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      busy_q       <= busy_d;
    end
  end

  assign WE     = we_q;
  assign AW     = aw_q;
  assign DataIn = data_q;
  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign busy   = busy_q;

endmodule
